iprf: RTL

//  Integer physical register file: responder for the RS operand-read interface and sink for the writeback broadcast.

---
 rtl/iprf_pkg.sv | 23 ++
 rtl/iprf_rd_port.sv | 43 ++++
 rtl/iprf.sv | 118 +++++++++++
 3 files changed

// File: rtl/iprf_pkg.sv
// Shared types and constants for the integer physical register file.
// Other units that produce writeback packets or preg ids import this package.
package iprf_pkg;

   localparam int IPRF_NUM_WRITES   = 2;
   localparam int IPRF_NUM_ENTS_DEF = 64;
   localparam int PRF_ID_W          = $clog2(IPRF_NUM_ENTS_DEF);
   localparam int RV_REG_DATA_W     = 32;

   typedef logic [PRF_ID_W-1:0]      t_prf_id;
   typedef logic [RV_REG_DATA_W-1:0] t_rv_reg_data;

   typedef struct packed {
      t_prf_id      pdst;
      t_rv_reg_data data;
   } t_prf_wr_pkt;

   // True for a preg that holds real state: nonzero and inside the array.
   function automatic logic prf_id_is_real(t_prf_id id, int num_ents);
      return (id != '0) && (int'(id) < num_ents);
   endfunction

endpackage

// File: rtl/iprf_rd_port.sv
// One operand read port of the physical register file.
// Selects the pre-edge array entry or the same-cycle writeback value and
// registers it, giving a fixed one-cycle read latency.
module iprf_rd_port
   import iprf_pkg::*;
#(
   parameter int NUM_ENTS = IPRF_NUM_ENTS_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rden,
   input  t_prf_id                    addr,
   input  t_rv_reg_data               storage [NUM_ENTS],
   input  logic [IPRF_NUM_WRITES-1:0] wr_en,
   input  t_prf_wr_pkt                wr_pkt  [IPRF_NUM_WRITES],
   output t_rv_reg_data               rddata
);

   t_rv_reg_data rd_value;

   // Array value, overridden by any matching writeback; later ports take priority.
   always_comb begin
      rd_value = '0;
      if (prf_id_is_real(addr, NUM_ENTS)) begin
         rd_value = storage[addr];
         for (int w = 0; w < IPRF_NUM_WRITES; w++) begin
            if (wr_en[w] && (wr_pkt[w].pdst == addr)) begin
               rd_value = wr_pkt[w].data;
            end
         end
      end
   end

   // Output flop; an idle port keeps its last data for the RS to ignore.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rddata <= '0;
      end else if (rden) begin
         rddata <= rd_value;
      end
   end

endmodule

// File: rtl/iprf.sv
// Integer physical register file: writeback sink, operand read responder
// and per-preg ready scoreboard. Preg 0 is hardwired to zero and always ready.
module iprf
   import iprf_pkg::*;
#(
   parameter int NUM_RD_PORTS  = 2,
   parameter int IPRF_NUM_ENTS = IPRF_NUM_ENTS_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IPRF_NUM_WRITES-1:0] iprf_wr_en_ro0,
   input  t_prf_wr_pkt                iprf_wr_pkt_ro0 [IPRF_NUM_WRITES],
   input  logic [NUM_RD_PORTS-1:0]    prf_rdens_rd0,
   input  t_prf_id                    prf_rdaddrs_rd0 [NUM_RD_PORTS],
   output t_rv_reg_data               prf_rddatas_rd1 [NUM_RD_PORTS],
   input  logic                       alloc_en_rn0,
   input  t_prf_id                    alloc_pdst_rn0,
   output logic [IPRF_NUM_ENTS-1:0]   iprf_ready
);

   t_rv_reg_data             storage     [IPRF_NUM_ENTS];
   logic [IPRF_NUM_ENTS-1:0] port_onehot [IPRF_NUM_WRITES];
   logic [IPRF_NUM_ENTS-1:0] ent_wr_en;
   t_rv_reg_data             ent_wr_data [IPRF_NUM_ENTS];
   logic [IPRF_NUM_ENTS-1:0] ready_next;

   // Decode each write port to a one-hot entry select; preg 0 is never selected.
   always_comb begin
      for (int w = 0; w < IPRF_NUM_WRITES; w++) begin
         port_onehot[w] = '0;
         if (iprf_wr_en_ro0[w] && prf_id_is_real(iprf_wr_pkt_ro0[w].pdst, IPRF_NUM_ENTS)) begin
            port_onehot[w][iprf_wr_pkt_ro0[w].pdst] = 1'b1;
         end
      end
   end

   // Merge port selects into per-entry enables and data; the highest port wins a tie.
   always_comb begin
      ent_wr_en = '0;
      for (int e = 0; e < IPRF_NUM_ENTS; e++) begin
         ent_wr_data[e] = '0;
         for (int w = 0; w < IPRF_NUM_WRITES; w++) begin
            if (port_onehot[w][e]) begin
               ent_wr_en[e]   = 1'b1;
               ent_wr_data[e] = iprf_wr_pkt_ro0[w].data;
            end
         end
      end
   end

   // Register array; entry 0 is only ever cleared, so it reads as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < IPRF_NUM_ENTS; e++) begin
            storage[e] <= '0;
         end
      end else begin
         for (int e = 1; e < IPRF_NUM_ENTS; e++) begin
            if (ent_wr_en[e]) begin
               storage[e] <= ent_wr_data[e];
            end
         end
      end
   end

   // Writeback marks a preg ready; a same-cycle allocate overrides it.
   always_comb begin
      ready_next = iprf_ready | ent_wr_en;
      if (alloc_en_rn0 && prf_id_is_real(alloc_pdst_rn0, IPRF_NUM_ENTS)) begin
         ready_next[alloc_pdst_rn0] = 1'b0;
      end
      ready_next[0] = 1'b1;
   end

   // Ready scoreboard flops; everything is ready out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iprf_ready <= '1;
      end else begin
         iprf_ready <= ready_next;
      end
   end

   for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd_port
      iprf_rd_port #(
         .NUM_ENTS (IPRF_NUM_ENTS)
      ) u_rd_port (
         .clk     (clk),
         .reset   (reset),
         .rden    (prf_rdens_rd0[r]),
         .addr    (prf_rdaddrs_rd0[r]),
         .storage (storage),
         .wr_en   (iprf_wr_en_ro0),
         .wr_pkt  (iprf_wr_pkt_ro0),
         .rddata  (prf_rddatas_rd1[r])
      );

      a_rd_addr_range: assert property (@(posedge clk) disable iff (reset)
         prf_rdens_rd0[r] |-> (int'(prf_rdaddrs_rd0[r]) < IPRF_NUM_ENTS));
   end

   for (genvar a = 0; a < IPRF_NUM_WRITES; a++) begin : g_wr_chk
      a_wr_addr_range: assert property (@(posedge clk) disable iff (reset)
         iprf_wr_en_ro0[a] |-> (int'(iprf_wr_pkt_ro0[a].pdst) < IPRF_NUM_ENTS));

      a_alloc_wr_same: assert property (@(posedge clk) disable iff (reset)
         !(alloc_en_rn0 && port_onehot[a][alloc_pdst_rn0]));

      for (genvar b = a + 1; b < IPRF_NUM_WRITES; b++) begin : g_pair
         a_dup_wr: assert property (@(posedge clk) disable iff (reset)
            !(port_onehot[a][iprf_wr_pkt_ro0[a].pdst] && port_onehot[b][iprf_wr_pkt_ro0[a].pdst]));
      end
   end

   a_alloc_range: assert property (@(posedge clk) disable iff (reset)
      alloc_en_rn0 |-> (int'(alloc_pdst_rn0) < IPRF_NUM_ENTS));

endmodule
